// File: rtl/ccff_pkg.sv
// rtl/ccff_pkg.sv - shared types and helpers for the configuration-chain loader
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ccff_state_e;

  // Words leave the serializer most-significant bit first.
  localparam bit MSB_FIRST = 1'b1;

  // Evaluated in 32-bit int so mixed-width operands never truncate early.
  function automatic int ccff_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// rtl/ccff_bitstream_loader_if.sv - bitstream word port between source and loader
interface ccff_bitstream_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/ccff_word_serializer.sv
// rtl/ccff_word_serializer.sv - holds one word and presents it to the chain a bit per cycle
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int FILL_W = $clog2(WORD_W + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              active,
  input  logic              clear,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [FILL_W-1:0] load_fill,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              empty
);
  logic [WORD_W-1:0] sreg;
  logic [FILL_W-1:0] fill;

  // Shift enable comes straight from the state and fill registers so the clock gate sees no hazards.
  assign ccff_shift_en = active && (fill != '0);
  assign empty         = (fill == '0);
  assign ccff_head     = MSB_FIRST ? sreg[WORD_W-1] : sreg[0];

  // Word register and remaining-bit count; a load only happens once the previous word is drained.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      sreg <= '0;
      fill <= '0;
    end else if (clear) begin
      fill <= '0;
    end else if (load) begin
      sreg <= load_data;
      fill <= load_fill;
    end else if (ccff_shift_en) begin
      sreg <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
      fill <= fill - FILL_W'(1);
    end
  end
endmodule

// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - config-chain loader top; CCFF_READBACK_EN adds chain readback outputs
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                    prog_clk,
  input  logic                    prog_reset_n,
  input  logic                    start,
  input  logic                    abort,
  ccff_bitstream_loader_if.slave  cfg,
  output logic                    ccff_head,
  output logic                    ccff_shift_en,
  input  logic                    ccff_tail,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        bit_count
`ifdef CCFF_READBACK_EN
  ,
  output logic [WORD_W-1:0]       rb_data,
  output logic                    rb_valid,
  output logic                    rb_overflow
`endif
);
  localparam int FILL_W = $clog2(WORD_W + 1);

  ccff_state_e       state_q, state_d;
  logic              start_load;
  logic              load_active;
  logic              accept;
  logic              last_shift;
  logic              word_empty;
  logic [FILL_W-1:0] load_fill;

  assign start_load  = (state_q == IDLE) && start && !abort;
  assign load_active = (state_q == LOAD);
  assign accept      = cfg.cfg_valid && cfg.cfg_ready;
  assign last_shift  = ccff_shift_en && (int'(bit_count) == CHAIN_LEN - 1);
  // The final word is truncated so only the bits the chain still needs are shifted.
  assign load_fill   = FILL_W'(ccff_min(WORD_W, CHAIN_LEN - int'(bit_count)));

  ccff_word_serializer #(
    .WORD_W (WORD_W),
    .FILL_W (FILL_W)
  ) u_serializer (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .active        (load_active),
    .clear         (abort || start_load),
    .load          (accept),
    .load_data     (cfg.cfg_data),
    .load_fill     (load_fill),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .empty         (word_empty)
  );

  // State register.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) state_q <= IDLE;
    else               state_q <= state_d;
  end

  // Next state; abort overrides everything including a simultaneous start.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = LOAD;
        LOAD:    if (last_shift) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy          = (state_q == LOAD);
    done          = (state_q == DONE);
    cfg.cfg_ready = load_active && word_empty && (int'(bit_count) < CHAIN_LEN);
  end

  // Bits shifted in this load; restarts on a new load or abort and stops at the chain length.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      bit_count <= '0;
    end else if (abort || start_load) begin
      bit_count <= '0;
    end else if (ccff_shift_en && (int'(bit_count) < CHAIN_LEN)) begin
      bit_count <= bit_count + CNT_W'(1);
    end
  end

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] rb_sreg;
  logic [FILL_W-1:0] rb_cnt;
  logic [WORD_W-1:0] rb_next;

  assign rb_next     = (rb_sreg << 1) | WORD_W'(ccff_tail);
  assign rb_overflow = 1'b0;

  // Collects old chain contents; a full group or the last partial group is published left-aligned.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      rb_sreg  <= '0;
      rb_cnt   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (abort || start_load) begin
        rb_sreg <= '0;
        rb_cnt  <= '0;
        rb_data <= '0;
      end else if (ccff_shift_en) begin
        rb_sreg <= rb_next;
        if ((rb_cnt == FILL_W'(WORD_W - 1)) || last_shift) begin
          rb_data  <= rb_next << (FILL_W'(WORD_W - 1) - rb_cnt);
          rb_valid <= 1'b1;
          rb_cnt   <= '0;
        end else begin
          rb_cnt <= rb_cnt + FILL_W'(1);
        end
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif
endmodule
